// File: rtl/rr_mux_n_if.sv
// rr_mux_n_if: bundles the channel-side and output-side handshake signals of
// the N:1 stream multiplexer. The mux itself uses the slave view; whatever
// drives the producers and the consumer uses the master view.
interface rr_mux_n_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic                  mode;
    logic [SELW-1:0]       sel;
    logic [NCH*WIDTH-1:0]  in_data;
    logic [NCH-1:0]        in_valid;
    logic [NCH-1:0]        in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic [SELW-1:0]       out_chan;
    logic                  out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/rr_mux_n.sv
// rr_mux_n: NCH:1 valid/ready stream multiplexer with a one-beat output
// register. mode=0 takes the channel named by sel; mode=1 arbitrates
// round-robin starting at ptr, which moves just past each granted channel.
module rr_mux_n #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic        clk,
    input  logic        rst,
    rr_mux_n_if.slave   bus
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  pick;
    logic             pick_ok;
    logic [SELW-1:0]  ptr_next;
    logic [WIDTH-1:0] pick_data;
    logic             load_en;
    logic             xfer;

    // Channel index base+offset folded back into 0..NCH-1 (base is always < NCH).
    function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base, input int offset);
        int j;
        j = int'(base) + offset;
        if (j >= NCH) begin
            j = j - NCH;
        end
        return SELW'(j);
    endfunction

    // The register can take a beat when empty or when its current beat leaves this cycle.
    assign load_en = !bus.out_valid || bus.out_ready;

    // Choose the candidate channel; scanning from the far end lets the closest valid channel to ptr win.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        if (!bus.mode) begin
            if (int'(bus.sel) < NCH) begin
                pick    = bus.sel;
                pick_ok = 1'b1;
            end
        end else begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (bus.in_valid[wrap_idx(ptr, i)]) begin
                    pick    = wrap_idx(ptr, i);
                    pick_ok = 1'b1;
                end
            end
        end
    end

    // Only the chosen channel sees ready, and nothing is ready while reset is held.
    always_comb begin
        bus.in_ready = '0;
        if (!rst && pick_ok) begin
            bus.in_ready[pick] = load_en;
        end
    end

    assign xfer      = !rst && pick_ok && load_en && bus.in_valid[pick];
    assign pick_data = bus.in_data[int'(pick)*WIDTH +: WIDTH];
    assign ptr_next  = (int'(pick) == NCH - 1) ? '0 : pick + SELW'(1);

    // Output register and round-robin pointer; a drained beat keeps its data/chan for visibility.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_chan  <= '0;
            ptr           <= '0;
        end else begin
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= pick_data;
                bus.out_chan  <= pick;
                if (bus.mode) begin
                    ptr <= ptr_next;
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule
